// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C slave transaction controller.
//   - state_e   : transaction FSM encoding (IDLE/ADDR/DATA/IGNORE)
//   - ERR_*     : bit positions inside the 4-bit sticky error vector
//   - *_DEF     : default values for FIFO_DEPTH and TIMEOUT_CYC
//   - sat_inc8  : saturating 8-bit increment used for the byte counter
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DATA   = 2'd2,
    ST_IGNORE = 2'd3
  } state_e;

  localparam int ERR_NACK       = 0;
  localparam int ERR_INCOMPLETE = 1;
  localparam int ERR_OVERFLOW   = 2;
  localparam int ERR_TIMEOUT    = 3;

  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 65535;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// i2c_byte_fifo: byte FIFO buffering received write data.
// Ports:
//   clk_i, rst_ni   clock / async active-low reset (empties the FIFO)
//   push_i, data_i  write request and byte
//   ready_i         downstream ready; pop = valid_o & ready_i
//   data_o, valid_o head byte (0 when empty) and not-empty flag
//   overflow_o      one-cycle pulse when a push is dropped
// Pointers carry one extra wrap bit so full/empty come straight from the
// registered pointers; valid_o therefore rises the cycle after a push.
module i2c_byte_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] fill;
  logic        empty, full, pop, push_ok;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (fill == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop. On empty, pop is already 0.
  assign pop        = ~empty & ready_i;
  assign push_ok    = push_i & (~full | pop);
  assign overflow_o = push_i & full & ~pop;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed when non-empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/i2c_xact_ctrl.sv
// i2c_xact_ctrl: I2C slave transaction controller. Consumes receiver event
// strobes, matches the 7-bit address, buffers write data in a FIFO and
// reports frame status.
// Ports:
//   clk_i, rst_ni                 clock / async active-low reset
//   ev_start_i, ev_stop_i         START / STOP strobes (may coincide)
//   ev_byte_i, ev_incomplete_i    byte strobe and partial-byte flag
//   rx_byte_i, rx_ack_i           received byte and 9th bit (1 = NACK)
//   own_addr_i                    static slave address
//   out_data_o/out_valid_o/out_ready_i  buffered write-data stream
//   busy_o, addr_match_o, rw_o, byte_cnt_o, frame_done_o  frame status
//   err_o                         sticky {timeout, overflow, incomplete, nack}
// Optional feature: define I2C_XACT_TIMEOUT_EN to abort a frame that sees
// no event for TIMEOUT_CYC cycles while in ADDR or DATA.
module i2c_xact_ctrl
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ev_start_i,
  input  logic       ev_stop_i,
  input  logic       ev_byte_i,
  input  logic       ev_incomplete_i,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_ack_i,
  input  logic [6:0] own_addr_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       addr_match_o,
  output logic       rw_o,
  output logic [7:0] byte_cnt_o,
  output logic       frame_done_o,
  output logic [3:0] err_o
);

`ifdef I2C_XACT_TIMEOUT_EN
  localparam int ERR_W = 4;
`else
  localparam int ERR_W = 3;
`endif

  state_e           state_q, state_d;
  logic             am_q, am_d, rw_q, rw_d, fd_q, fd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             push, fifo_ovf;

`ifdef I2C_XACT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          any_ev, active, tmo_hit;

  assign any_ev  = ev_start_i | ev_stop_i | ev_byte_i;
  assign active  = (state_q == ST_ADDR) | (state_q == ST_DATA);
  // Fires on the TIMEOUT_CYC-th consecutive event-free cycle of a frame.
  assign tmo_hit = active & ~any_ev & (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign tmo_d   = (any_ev | ~active | tmo_hit) ? '0 : tmo_q + TW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    am_d    = am_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    push    = 1'b0;
    if (ev_start_i) begin
      // START (incl. repeated START with a coincident STOP) wins over all.
      state_d = ST_ADDR;
      am_d    = 1'b0;
      rw_d    = 1'b0;
      cnt_d   = '0;
      err_d   = '0;
      fd_d    = (state_q == ST_DATA);
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (ev_byte_i) begin
            if (ev_incomplete_i) begin
              err_d[ERR_INCOMPLETE] = 1'b1;
              state_d = ST_IGNORE;
            end else if (rx_byte_i[7:1] == own_addr_i) begin
              state_d = ST_DATA;
              am_d    = 1'b1;
              rw_d    = rx_byte_i[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (ev_stop_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (ev_byte_i) begin
            if (ev_incomplete_i) begin
              err_d[ERR_INCOMPLETE] = 1'b1;
            end else begin
              cnt_d = sat_inc8(cnt_q);
              push  = ~rw_q;
              if (rx_ack_i) err_d[ERR_NACK] = 1'b1;
            end
          end
          if (ev_stop_i) begin
            fd_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_IGNORE: if (ev_stop_i) state_d = ST_IDLE;
        default: ;
      endcase
      if (fifo_ovf) err_d[ERR_OVERFLOW] = 1'b1;
`ifdef I2C_XACT_TIMEOUT_EN
      if (tmo_hit) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        state_d = ST_IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      am_q    <= 1'b0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      am_q    <= am_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
    end
  end

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .data_i     (rx_byte_i),
    .ready_i    (out_ready_i),
    .data_o     (out_data_o),
    .valid_o    (out_valid_o),
    .overflow_o (fifo_ovf)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign addr_match_o = am_q;
  assign rw_o         = rw_q;
  assign byte_cnt_o   = cnt_q;
  assign frame_done_o = fd_q;
`ifdef I2C_XACT_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = {1'b0, err_q};
`endif

endmodule

// File: tb/tb_i2c_xact_ctrl.sv
// Self-checking bench for i2c_xact_ctrl: directed scenarios followed by
// randomized frames, every cycle compared against a queue-based model.
module tb_i2c_xact_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 100;
  localparam logic [6:0] OWN = 7'h2A;
  localparam int M_IDLE = 0, M_ADDR = 1, M_DATA = 2, M_IGN = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ev_start = 0, ev_stop = 0, ev_byte = 0, ev_inc = 0, rx_ack = 0;
  logic [7:0] rx_byte = '0;
  logic out_ready = 0;
  logic [7:0] out_data, byte_cnt;
  logic out_valid, busy, addr_match, rw, frame_done;
  logic [3:0] err;

  always #5 clk = ~clk;

  i2c_xact_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ev_start_i(ev_start), .ev_stop_i(ev_stop), .ev_byte_i(ev_byte),
    .ev_incomplete_i(ev_inc), .rx_byte_i(rx_byte), .rx_ack_i(rx_ack),
    .own_addr_i(OWN),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .addr_match_o(addr_match), .rw_o(rw),
    .byte_cnt_o(byte_cnt), .frame_done_o(frame_done), .err_o(err)
  );

  int checks = 0, failures = 0;

  // reference model state
  int m_st, m_cnt;
  bit m_am, m_rw, m_fd;
  bit [3:0] m_err;
  logic [7:0] fq[$];
`ifdef I2C_XACT_TIMEOUT_EN
  int m_to;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_am = 0; m_rw = 0; m_fd = 0; m_err = '0;
    fq.delete();
`ifdef I2C_XACT_TIMEOUT_EN
    m_to = 0;
`endif
  endtask

  task automatic check_all();
    chk("busy", busy, m_st != M_IDLE);
    chk("addr_match", addr_match, m_am);
    chk("rw", rw, m_rw);
    chk("byte_cnt", byte_cnt, m_cnt);
    chk("err", err, m_err);
    chk("frame_done", frame_done, m_fd);
    chk("out_valid", out_valid, fq.size() > 0);
    if (fq.size() > 0) chk("out_data", out_data, fq[0]);
  endtask

  // One clock cycle: drive events, advance the model, check after the edge.
  task automatic step(input bit s, input bit p, input bit b, input bit inc,
                      input logic [7:0] d, input bit ack);
    bit pop, push;
    ev_start = s; ev_stop = p; ev_byte = b; ev_inc = inc; rx_byte = d; rx_ack = ack;
    pop  = out_ready && (fq.size() > 0);
    push = 0;
    m_fd = 0;
`ifdef I2C_XACT_TIMEOUT_EN
    if ((s || p || b) || !(m_st == M_ADDR || m_st == M_DATA)) m_to = 0;
    else m_to++;
`endif
    if (s) begin
      m_fd = (m_st == M_DATA);
      m_st = M_ADDR; m_am = 0; m_rw = 0; m_cnt = 0; m_err = '0;
    end else begin
      case (m_st)
        M_ADDR:
          if (b) begin
            if (inc) begin m_err[1] = 1; m_st = M_IGN; end
            else if (d[7:1] == OWN) begin m_st = M_DATA; m_am = 1; m_rw = d[0]; end
            else m_st = M_IGN;
          end else if (p) m_st = M_IDLE;
        M_DATA: begin
          if (b) begin
            if (inc) m_err[1] = 1;
            else begin
              if (m_cnt < 255) m_cnt++;
              if (!m_rw) push = 1;
              if (ack) m_err[0] = 1;
            end
          end
          if (p) begin m_fd = 1; m_st = M_IDLE; end
        end
        M_IGN: if (p) m_st = M_IDLE;
        default: ;
      endcase
`ifdef I2C_XACT_TIMEOUT_EN
      if (m_to == TO) begin m_err[3] = 1; m_st = M_IDLE; m_to = 0; end
`endif
    end
    if (pop) void'(fq.pop_front());
    if (push) begin
      if (fq.size() < DEPTH) fq.push_back(d);
      else m_err[2] = 1;
    end
    @(posedge clk);
    #1;
    ev_start = 0; ev_stop = 0; ev_byte = 0; ev_inc = 0; rx_byte = '0; rx_ack = 0;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0);
  endtask
  task automatic start_ev(); step(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic stop_ev();  step(0, 1, 0, 0, 8'h00, 0); endtask
  task automatic byte_ev(input logic [7:0] d, input bit ack, input bit inc);
    step(0, 0, 1, inc, d, ack);
  endtask

  task automatic drain(output int pops);
    pops = 0;
    out_ready = 1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (out_valid) pops++;
      idle(1);
    end
    out_ready = 0;
  endtask

  initial begin
    int pops;
    model_reset();
    // reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_fd", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(2);

    // matched write of two data bytes
    start_ev(); byte_ev(8'h54, 0, 0); byte_ev(8'hA5, 0, 0); byte_ev(8'h3C, 0, 0);
    stop_ev(); idle(1);
    chk("w_cnt", byte_cnt, 2);
    chk("w_am", addr_match, 1);
    chk("w_err", err, 0);
    chk("w_head", out_data, 8'hA5);
    drain(pops);
    chk("w_pops", pops, 2);

    // non-matching address: frame ignored
    start_ev(); byte_ev(8'h56, 0, 0);
    for (int i = 0; i < 3; i++) byte_ev(8'h10 + 8'(i), 0, 0);
    stop_ev(); idle(1);
    chk("ign_am", addr_match, 0);
    chk("ign_valid", out_valid, 0);

    // overflow with downstream stalled
    out_ready = 0;
    start_ev(); byte_ev(8'h54, 0, 0);
    for (int i = 0; i < 5; i++) byte_ev(8'hB0 + 8'(i), 0, 0);
    stop_ev();
    chk("ovf_err", err[2], 1);
    drain(pops);
    chk("ovf_pops", pops, 4);

    // push into full FIFO accepted when a pop happens in the same cycle
    start_ev(); byte_ev(8'h54, 0, 0);
    for (int i = 0; i < 4; i++) byte_ev(8'hC0 + 8'(i), 0, 0);
    out_ready = 1; byte_ev(8'h77, 0, 0); out_ready = 0;
    chk("fullpop_err", err[2], 0);
    stop_ev();
    drain(pops);
    chk("fullpop_pops", pops, 4);

    // repeated START (start+stop together) ending a data frame
    start_ev(); byte_ev(8'h54, 0, 0); byte_ev(8'h01, 0, 0); byte_ev(8'h02, 0, 0);
    step(1, 1, 0, 0, 8'h00, 0);
    chk("rs_fd", frame_done, 1);
    chk("rs_busy", busy, 1);
    byte_ev(8'h55, 0, 0);
    chk("rs_rw", rw, 1);
    chk("rs_err", err, 0);
    byte_ev(8'h99, 0, 0);
    stop_ev();
    drain(pops);
    chk("rs_pops", pops, 2);

    // NACK then incomplete byte
    start_ev(); byte_ev(8'h54, 0, 0); byte_ev(8'h12, 1, 0); byte_ev(8'h34, 0, 1);
    stop_ev();
    chk("ni_err", err, 4'b0011);
    chk("ni_cnt", byte_cnt, 1);
    drain(pops);
    chk("ni_pops", pops, 1);

    // reset mid-frame: everything cleared, no frame_done afterwards
    start_ev(); byte_ev(8'h54, 0, 0); byte_ev(8'h11, 0, 0);
    rst_n = 0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_am", addr_match, 0);
    chk("mr_cnt", byte_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(3);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int nb;
      logic [7:0] a;
      out_ready = 1'($urandom_range(0, 1));
      start_ev();
      idle($urandom_range(0, 2));
      a = {($urandom_range(0, 1) == 1) ? OWN : 7'($urandom), 1'($urandom_range(0, 3) == 0)};
      byte_ev(a, 0, ($urandom_range(0, 9) == 0));
      nb = $urandom_range(0, 7);
      for (int i = 0; i < nb; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        byte_ev(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        idle($urandom_range(0, 2));
      end
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) stop_ev();
      idle($urandom_range(0, 2));
    end
    stop_ev();
    drain(pops);
    chk("rand_empty", out_valid, 0);

    // idle frame: timeout only when the feature is built in
    start_ev();
`ifdef I2C_XACT_TIMEOUT_EN
    idle(TO + 5);
    chk("tmo_err", err[3], 1);
    chk("tmo_busy", busy, 0);
`else
    idle(30);
    chk("notmo_err", err[3], 0);
    chk("notmo_busy", busy, 1);
    stop_ev();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_xact_ctrl.md
I2C_XACT_CTRL -- requirements
Module: i2c_xact_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of entries in the data buffer (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYC, default 65535, idle-cycle limit inside an active frame (used only with I2C_XACT_TIMEOUT_EN).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge; reset  in  1  asynchronous active-low reset.
REQ-004 ev_start  in  1  receiver START strobe, one cycle.
REQ-005 ev_stop  in  1  receiver STOP strobe, one cycle; may coincide with ev_start on a repeated START.
REQ-006 ev_byte  in  1  receiver byte-received strobe, one cycle.
REQ-007 ev_incomplete  in  1  receiver partial-byte flag, valid with ev_byte.
REQ-008 rx_byte  in  8  received byte, valid with ev_byte.
REQ-009 rx_ack  in  1  ninth bit sampled (0 = ACK, 1 = NACK), valid with ev_byte.
REQ-010 own_addr  in  7  slave address to match, static.
REQ-011 out_data  out  8  buffered write byte, head of FIFO.
REQ-012 out_valid  out  1  FIFO not empty.
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 busy  out  1  state is not IDLE.
REQ-015 addr_match  out  1  current frame is addressed to own_addr.
REQ-016 rw  out  1  R/W bit of current frame.
REQ-017 byte_cnt  out  8  data bytes in current frame, saturating.
REQ-018 frame_done  out  1  one-cycle pulse at the end of a matched frame.
REQ-019 err  out  4  sticky {timeout, overflow, incomplete, nack}, cleared on ev_start.

Function
REQ-020 The FSM SHALL have states IDLE, ADDR, DATA, IGNORE, and all events SHALL be sampled on rising clk.
REQ-021 ev_start in any state SHALL move the FSM to ADDR, clear err, byte_cnt, addr_match and rw, and take priority over a simultaneous ev_stop.
REQ-022 In ADDR, a complete byte SHALL go to DATA with addr_match=1 and rw=rx_byte[0] when rx_byte[7:1]==own_addr, and SHALL go to IGNORE otherwise.
REQ-023 In ADDR, an incomplete byte SHALL set err.incomplete and go to IGNORE, and ev_stop alone SHALL return to IDLE.
REQ-024 In DATA, a complete byte SHALL increment byte_cnt (saturating at 255), push rx_byte into the FIFO when rw=0, and set err.nack when rx_ack=1.
REQ-025 In DATA, an incomplete byte SHALL set err.incomplete and SHALL NOT push or increment.
REQ-026 In DATA, ev_stop, or ev_start that ends the frame, SHALL pulse frame_done for one cycle, and ev_stop SHALL then return to IDLE.
REQ-027 In IGNORE, only ev_start and ev_stop SHALL be acted on, and bytes SHALL be discarded.
REQ-028 The FIFO SHALL use registered pointers, and out_valid SHALL rise the cycle after the push (1-cycle latency).
REQ-029 A pop SHALL occur on out_valid & out_ready.
REQ-030 A push while full SHALL drop the byte and set err.overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-031 A push and a pop on an empty FIFO in the same cycle SHALL accept only the push.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 FIFO contents SHALL persist across frames and SHALL NOT be flushed by ev_start or ev_stop.

Reset
REQ-034 On reset low, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and every output SHALL be 0 (out_data=8'h00), asynchronously.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no frame_done pulse.

Configuration
REQ-036 With I2C_XACT_TIMEOUT_EN defined, a counter SHALL clear on any event and count while state is ADDR or DATA; on reaching TIMEOUT_CYC it SHALL set err.timeout and force IDLE.
REQ-037 Without I2C_XACT_TIMEOUT_EN, there SHALL be no counter, err[3] SHALL be tied to 0, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-038 A shared package i2c_pkg SHALL hold the FSM state encoding, the err bit indices and the default parameters.
REQ-039 The FIFO SHALL be a sub-module i2c_byte_fifo, parameterised by depth.

Verification
REQ-040 own_addr=7'h2A; START, byte 8'h54 ACK, 8'hA5 ACK, 8'h3C ACK, STOP -> addr_match=1, rw=0, FIFO pops A5 then 3C, byte_cnt=2, one frame_done, err=0.
REQ-041 START, byte 8'h56 (addr 2B), 3 data bytes, STOP -> IGNORE, no push, no frame_done, addr_match=0.
REQ-042 out_ready=0, matched write of 5 bytes with FIFO_DEPTH=4 -> first 4 buffered, err.overflow=1; then out_ready=1 -> exactly 4 pops.
REQ-043 Matched write; ev_start+ev_stop in the same cycle after 2 bytes, then byte 8'h55 -> frame_done once, err cleared, FSM in ADDR then DATA with rw=1, no push.
REQ-044 Data byte with rx_ack=1, then an incomplete byte, then STOP -> err=4'b0011, byte_cnt=1.
REQ-045 With I2C_XACT_TIMEOUT_EN defined and TIMEOUT_CYC=100: START, no further events -> after 100 cycles err.timeout=1, busy=0.
